// File: rtl/vsd_axi_pkg.sv
// Shared FSM encoding and AXI response/protection constants for the VSD-to-AXI4-Lite master.
package vsd_axi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRdAddr,
        StRdData,
        StWrReq,
        StWrResp
    } state_e;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    localparam logic [2:0] DefaultProt = 3'b000;

endpackage

// File: rtl/vsd_to_axi4_master.sv
// Converts the core's VSD memory port into single-beat AXI4-Lite reads and writes,
// one transaction outstanding. Every AXI output comes straight from a flop.
module vsd_to_axi4_master
    import vsd_axi_pkg::*;
#(
    parameter logic [2:0]  AXI_PROT  = DefaultProt,
    parameter logic [31:0] RDATA_ERR = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_addr,
    input  logic        mem_rstrb,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    output logic [31:0] mem_rdata,
    output logic        mem_rbusy,
    output logic        mem_wbusy,
    output logic [31:0] m_araddr,
    output logic [2:0]  m_arprot,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    output logic        m_rready,
    output logic [31:0] m_awaddr,
    output logic [2:0]  m_awprot,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready,
    output logic        bus_err
);

    state_e      state_q, state_d;
    logic [31:0] araddr_q, araddr_d, awaddr_q, awaddr_d;
    logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        arvalid_q, arvalid_d, awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic        rready_q, rready_d, bready_q, bready_d;
    logic        rbusy_q, rbusy_d, wbusy_q, wbusy_d;
    logic        bus_err_q, bus_err_d, rd_pend_q, rd_pend_d;
    logic [31:0] addr_aligned;
    logic        unused_addr_lsbs;

    assign addr_aligned     = {mem_addr[31:2], 2'b00};
    assign unused_addr_lsbs = ^mem_addr[1:0];

    always_comb begin
        state_d   = state_q;
        araddr_d  = araddr_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        arvalid_d = arvalid_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        rready_d  = rready_q;
        bready_d  = bready_q;
        rbusy_d   = rbusy_q;
        wbusy_d   = wbusy_q;
        bus_err_d = bus_err_q;
        rd_pend_d = rd_pend_q;
        unique case (state_q)
            StIdle: begin
                if (mem_wmask != 4'b0000) begin
                    awaddr_d  = addr_aligned;
                    wdata_d   = mem_wdata;
                    wstrb_d   = mem_wmask;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    wbusy_d   = 1'b1;
                    state_d   = StWrReq;
                    // A read strobed alongside the write is replayed after the B handshake.
                    if (mem_rstrb) begin
                        rd_pend_d = 1'b1;
                        araddr_d  = addr_aligned;
                        rbusy_d   = 1'b1;
                    end
                end else if (mem_rstrb) begin
                    araddr_d  = addr_aligned;
                    arvalid_d = 1'b1;
                    rbusy_d   = 1'b1;
                    state_d   = StRdAddr;
                end
            end
            StRdAddr: begin
                if (m_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = StRdData;
                end
            end
            StRdData: begin
                if (m_rvalid) begin
                    rdata_d  = (m_rresp == RespOkay) ? m_rdata : RDATA_ERR;
                    if (m_rresp != RespOkay) bus_err_d = 1'b1;
                    rready_d = 1'b0;
                    rbusy_d  = 1'b0;
                    state_d  = StIdle;
                end
            end
            StWrReq: begin
                if (m_awready) awvalid_d = 1'b0;
                if (m_wready)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = StWrResp;
                end
            end
            StWrResp: begin
                if (m_bvalid) begin
                    bready_d = 1'b0;
                    wbusy_d  = 1'b0;
                    if (m_bresp != RespOkay) bus_err_d = 1'b1;
                    if (rd_pend_q) begin
                        rd_pend_d = 1'b0;
                        arvalid_d = 1'b1;
                        state_d   = StRdAddr;
                    end else begin
                        state_d   = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            araddr_q  <= '0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            rready_q  <= 1'b0;
            bready_q  <= 1'b0;
            rbusy_q   <= 1'b0;
            wbusy_q   <= 1'b0;
            bus_err_q <= 1'b0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            araddr_q  <= araddr_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            arvalid_q <= arvalid_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            rready_q  <= rready_d;
            bready_q  <= bready_d;
            rbusy_q   <= rbusy_d;
            wbusy_q   <= wbusy_d;
            bus_err_q <= bus_err_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_rbusy = rbusy_q;
    assign mem_wbusy = wbusy_q;
    assign m_araddr  = araddr_q;
    assign m_arprot  = AXI_PROT;
    assign m_arvalid = arvalid_q;
    assign m_rready  = rready_q;
    assign m_awaddr  = awaddr_q;
    assign m_awprot  = AXI_PROT;
    assign m_awvalid = awvalid_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign m_wvalid  = wvalid_q;
    assign m_bready  = bready_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_vsd_to_axi4_master.sv
// Self-checking bench: table vectors, corner-case sequences and random traffic against a
// word-level memory model, with a configurable AXI4-Lite responder.
module tb_vsd_to_axi4_master;
    import vsd_axi_pkg::*;

    logic        clk, rst_n;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rstrb, mem_rbusy, mem_wbusy;
    logic [3:0]  mem_wmask;
    logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
    logic [2:0]  m_arprot, m_awprot;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [1:0]  m_rresp, m_bresp;
    logic [3:0]  m_wstrb;
    logic        bus_err;

    vsd_to_axi4_master dut (
        .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_rstrb(mem_rstrb),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
        .mem_rbusy(mem_rbusy), .mem_wbusy(mem_wbusy), .m_araddr(m_araddr),
        .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid),
        .m_awready(m_awready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid),
        .m_wready(m_wready), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Responder: ready after a programmable wait, R/B one cycle after their requests complete.
    int          ar_delay = 0, aw_delay = 0, w_delay = 0;
    logic [1:0]  rresp_cfg = RespOkay, bresp_cfg = RespOkay;
    int          ar_cnt, aw_cnt, w_cnt;
    logic [31:0] smem [4096] = '{default: 32'h0};
    logic        rv_q, bv_q, aw_got, w_got;
    logic [31:0] s_rdata_q, aw_addr_s, w_data_s;
    logic [3:0]  w_strb_s;
    logic [1:0]  s_rresp_q, s_bresp_q;
    int          n_b = 0;
    time         t_ar = 0, t_b = 0;
    logic        s_aw_have, s_w_have;
    logic [31:0] s_aw_addr, s_w_data;
    logic [3:0]  s_w_strb;

    assign m_arready = m_arvalid && (ar_cnt >= ar_delay);
    assign m_awready = m_awvalid && !aw_got && (aw_cnt >= aw_delay);
    assign m_wready  = m_wvalid && !w_got && (w_cnt >= w_delay);
    assign m_rvalid  = rv_q;
    assign m_rdata   = s_rdata_q;
    assign m_rresp   = s_rresp_q;
    assign m_bvalid  = bv_q;
    assign m_bresp   = s_bresp_q;
    assign s_aw_have = aw_got || (m_awvalid && m_awready);
    assign s_w_have  = w_got || (m_wvalid && m_wready);
    assign s_aw_addr = aw_got ? aw_addr_s : m_awaddr;
    assign s_w_data  = w_got ? w_data_s : m_wdata;
    assign s_w_strb  = w_got ? w_strb_s : m_wstrb;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0;
            rv_q <= 1'b0; bv_q <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
            s_rdata_q <= '0; s_rresp_q <= '0; s_bresp_q <= '0;
            aw_addr_s <= '0; w_data_s <= '0; w_strb_s <= '0;
        end else begin
            ar_cnt <= (m_arvalid && !m_arready) ? ar_cnt + 1 : 0;
            aw_cnt <= (m_awvalid && !m_awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (m_wvalid && !m_wready) ? w_cnt + 1 : 0;
            if (m_arvalid && m_arready) begin
                rv_q      <= 1'b1;
                s_rdata_q <= smem[m_araddr[13:2]];
                s_rresp_q <= rresp_cfg;
                t_ar      <= $time;
            end else if (rv_q && m_rready) begin
                rv_q <= 1'b0;
            end
            if (s_aw_have && s_w_have) begin
                if (bresp_cfg == RespOkay)
                    for (int i = 0; i < 4; i++)
                        if (s_w_strb[i]) smem[s_aw_addr[13:2]][8*i +: 8] <= s_w_data[8*i +: 8];
                bv_q      <= 1'b1;
                s_bresp_q <= bresp_cfg;
                aw_got    <= 1'b0;
                w_got     <= 1'b0;
            end else begin
                if (m_awvalid && m_awready) begin aw_got <= 1'b1; aw_addr_s <= m_awaddr; end
                if (m_wvalid && m_wready) begin
                    w_got <= 1'b1; w_data_s <= m_wdata; w_strb_s <= m_wstrb;
                end
            end
            if (bv_q && m_bready) begin bv_q <= 1'b0; n_b <= n_b + 1; t_b <= $time; end
        end
    end

    // Valid/payload stability while waiting for ready.
    logic        p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
    logic [31:0] p_araddr, p_awaddr, p_wdata;
    logic [3:0]  p_wstrb;
    int          n_viol = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_arv <= 1'b0; p_arr <= 1'b0; p_awv <= 1'b0; p_awr <= 1'b0; p_wv <= 1'b0;
            p_wr <= 1'b0; p_araddr <= '0; p_awaddr <= '0; p_wdata <= '0; p_wstrb <= '0;
        end else begin
            if ((p_arv && !p_arr && (!m_arvalid || m_araddr != p_araddr)) ||
                (p_awv && !p_awr && (!m_awvalid || m_awaddr != p_awaddr)) ||
                (p_wv && !p_wr && (!m_wvalid || m_wdata != p_wdata || m_wstrb != p_wstrb)))
                n_viol <= n_viol + 1;
            p_arv <= m_arvalid; p_arr <= m_arready; p_araddr <= m_araddr;
            p_awv <= m_awvalid; p_awr <= m_awready; p_awaddr <= m_awaddr;
            p_wv <= m_wvalid; p_wr <= m_wready; p_wdata <= m_wdata; p_wstrb <= m_wstrb;
        end
    end

    // Reference model: word-addressed memory, sticky error, last read value.
    logic [31:0] ref_mem [bit [29:0]];
    logic [31:0] exp_rdata;
    logic        exp_err;

    task automatic model_txn(input bit rd, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [3:0] wm,
                             input logic [1:0] rr, input logic [1:0] br);
        logic [31:0] w;
        if (wr) begin
            if (br == RespOkay) begin
                w = ref_mem.exists(addr[31:2]) ? ref_mem[addr[31:2]] : 32'h0;
                for (int i = 0; i < 4; i++) if (wm[i]) w[8*i +: 8] = wd[8*i +: 8];
                ref_mem[addr[31:2]] = w;
            end else begin
                exp_err = 1'b1;
            end
        end
        if (rd) begin
            if (rr == RespOkay) begin
                exp_rdata = ref_mem.exists(addr[31:2]) ? ref_mem[addr[31:2]] : 32'h0;
            end else begin
                exp_rdata = 32'hDEAD_BEEF;
                exp_err   = 1'b1;
            end
        end
    endtask

    int txn_lat;
    bit txn_gap;

    task automatic start_req(input bit rd, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [3:0] wm);
        mem_addr  = addr;
        mem_wdata = wd;
        mem_wmask = wr ? wm : 4'b0000;
        mem_rstrb = rd;
        @(posedge clk); #1;
        mem_rstrb = 1'b0;
        mem_wmask = 4'b0000;
    endtask

    task automatic wait_idle(input bit chk_gap);
        txn_lat = 1;
        txn_gap = 1'b0;
        while ((mem_rbusy || mem_wbusy) && txn_lat < 200) begin
            if (chk_gap && !mem_rbusy) txn_gap = 1'b1;
            @(posedge clk); #1;
            txn_lat++;
        end
        check("idle_reached", {30'b0, mem_rbusy, mem_wbusy}, 32'h0);
    endtask

    task automatic run_checked(input string tag, input bit rd, input bit wr,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [3:0] wm);
        model_txn(rd, wr, addr, wd, wm, rresp_cfg, bresp_cfg);
        start_req(rd, wr, addr, wd, wm);
        wait_idle(rd && wr);
        check({tag, "_rdata"}, mem_rdata, exp_rdata);
        check({tag, "_err"}, {31'b0, bus_err}, {31'b0, exp_err});
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [1:0]  rresp;
        logic [1:0]  bresp;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    localparam int NVec = 12;
    vec_t vecs [NVec];

    initial begin
        bit ok;
        int nb0;
        vecs[0]  = '{0, 1, 32'h104, 32'h1234_5678, 4'hF, RespOkay, RespOkay, 32'h0, 0, 3};
        vecs[1]  = '{1, 0, 32'h104, 32'h0, 4'h0, RespOkay, RespOkay, 32'h1234_5678, 0, 3};
        vecs[2]  = '{1, 0, 32'h107, 32'h0, 4'h0, RespOkay, RespOkay, 32'h1234_5678, 0, 3};
        vecs[3]  = '{0, 1, 32'h108, 32'hFFFF_FFFF, 4'hF, RespOkay, RespOkay, 32'h1234_5678, 0, 3};
        vecs[4]  = '{0, 1, 32'h108, 32'hAABB_CCDD, 4'h5, RespOkay, RespOkay, 32'h1234_5678, 0, 3};
        vecs[5]  = '{1, 0, 32'h108, 32'h0, 4'h0, RespOkay, RespOkay, 32'hFFBB_FFDD, 0, 3};
        vecs[6]  = '{1, 1, 32'h200, 32'hCAFE_F00D, 4'hF, RespOkay, RespOkay, 32'hCAFE_F00D, 0, 5};
        vecs[7]  = '{1, 0, 32'h104, 32'h0, 4'h0, RespSlvErr, RespOkay, 32'hDEAD_BEEF, 1, 3};
        vecs[8]  = '{0, 1, 32'h300, 32'h0BAD_F00D, 4'hF, RespOkay, RespOkay, 32'hDEAD_BEEF, 1, 3};
        vecs[9]  = '{1, 0, 32'h300, 32'h0, 4'h0, RespOkay, RespOkay, 32'h0BAD_F00D, 1, 3};
        vecs[10] = '{0, 1, 32'h300, 32'h0, 4'hF, RespOkay, RespDecErr, 32'h0BAD_F00D, 1, 3};
        vecs[11] = '{1, 0, 32'h300, 32'h0, 4'h0, RespOkay, RespOkay, 32'h0BAD_F00D, 1, 3};

        rst_n = 1'b0; mem_addr = '0; mem_rstrb = 1'b0; mem_wdata = '0; mem_wmask = '0;
        exp_err = 1'b0; exp_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {24'b0, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready,
                             mem_rbusy, mem_wbusy, bus_err}, 32'h0);
        check("reset_rdata", mem_rdata, 32'h0);
        check("prot", {26'b0, m_arprot, m_awprot}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NVec; i++) begin
            rresp_cfg = vecs[i].rresp;
            bresp_cfg = vecs[i].bresp;
            model_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wmask,
                      vecs[i].rresp, vecs[i].bresp);
            start_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wmask);
            wait_idle(vecs[i].rd && vecs[i].wr);
            check($sformatf("vec%0d_rdata", i), mem_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), {31'b0, bus_err}, {31'b0, vecs[i].exp_err});
            check($sformatf("vec%0d_lat", i), txn_lat, vecs[i].exp_lat);
            if (vecs[i].rd && vecs[i].wr) begin
                check("both_ar_after_b", {31'b0, t_ar > t_b}, 32'h1);
                check("both_rbusy_gap", {31'b0, txn_gap}, 32'h0);
            end
        end
        rresp_cfg = RespOkay;
        bresp_cfg = RespOkay;

        // Skewed write: W accepted two cycles before AW.
        aw_delay = 3; w_delay = 1; nb0 = n_b;
        model_txn(0, 1, 32'h0040_0008, 32'h0000_001F, 4'b0011, RespOkay, RespOkay);
        start_req(0, 1, 32'h0040_0008, 32'h0000_001F, 4'b0011);
        check("skew_awaddr", m_awaddr, 32'h0040_0008);
        check("skew_wstrb", {28'b0, m_wstrb}, 32'h3);
        check("skew_wdata", m_wdata, 32'h0000_001F);
        repeat (2) begin @(posedge clk); #1; end
        check("skew_w_first", {30'b0, m_awvalid, m_wvalid}, 32'h2);
        wait_idle(0);
        check("skew_one_b", n_b - nb0, 32'h1);
        aw_delay = 0; w_delay = 0;
        run_checked("skew_readback", 1, 0, 32'h0040_0008, 32'h0, 4'h0);

        // AR backpressure for 10 cycles.
        ar_delay = 10;
        model_txn(1, 0, 32'h104, 32'h0, 4'h0, RespOkay, RespOkay);
        start_req(1, 0, 32'h104, 32'h0, 4'h0);
        check("bp_araddr", m_araddr, 32'h0000_0104);
        ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (!(m_arvalid && m_araddr == 32'h104 && !m_rready)) ok = 1'b0;
            @(posedge clk); #1;
        end
        check("bp_hold", {31'b0, ok}, 32'h1);
        wait_idle(0);
        check("bp_rdata", mem_rdata, exp_rdata);
        ar_delay = 0;

        // Asynchronous reset while the write waits for AW/W ready.
        aw_delay = 50; w_delay = 50;
        start_req(0, 1, 32'h2000, 32'h5555_5555, 4'hF);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ctrl", {24'b0, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready,
                            mem_rbusy, mem_wbusy, bus_err}, 32'h0);
        check("arst_rdata", mem_rdata, 32'h0);
        exp_err = 1'b0; exp_rdata = '0;
        @(negedge clk);
        rst_n = 1'b1;
        aw_delay = 0; w_delay = 0;
        run_checked("post_rst_wr", 0, 1, 32'h2004, 32'h600D_F00D, 4'hF);
        run_checked("post_rst_rd", 1, 0, 32'h2004, 32'h0, 4'h0);

        // Random traffic over a small window so reads hit earlier writes.
        for (int n = 0; n < 200; n++) begin
            int          op;
            logic [31:0] a, d;
            logic [3:0]  m;
            op = $urandom_range(0, 2);
            a  = 32'h2000 + ($urandom_range(0, 31) << 2) + $urandom_range(0, 3);
            d  = $urandom;
            m  = 4'($urandom_range(1, 15));
            ar_delay  = $urandom_range(0, 3);
            aw_delay  = $urandom_range(0, 3);
            w_delay   = $urandom_range(0, 3);
            rresp_cfg = ($urandom_range(0, 15) == 0) ? RespSlvErr : RespOkay;
            bresp_cfg = ($urandom_range(0, 15) == 0) ? RespDecErr : RespOkay;
            run_checked($sformatf("rnd%0d", n), op != 1, op != 0, a, d, m);
        end

        check("handshake_stability", n_viol, 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
